// File: rtl/seg7_pkg.sv
// Shared types and constants for the four-digit BCD counter and its
// time-shared seven-segment decoder.
//   NUM_DIGITS / PTR_W : digit count and scan pointer width
//   bcd_t / bcd_vec_t  : one BCD digit / the full four-digit count
//   seg_t              : [0:6] active-low pattern, bit 0 = segment a
//   SEG_*              : digit patterns and the blank pattern
//   clamp_digit        : limits a loaded nibble to 9
//   bcd_step           : +1 or -1 on the whole count with carry/borrow
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int PTR_W      = 2;

  typedef logic [3:0]                bcd_t;
  typedef bcd_t [NUM_DIGITS-1:0]     bcd_vec_t;
  typedef logic [PTR_W-1:0]          ptr_t;
  typedef logic [0:6]                seg_t;

  localparam bcd_t BCD_BLANK = 4'hF;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;

  function automatic bcd_t clamp_digit(bcd_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Ripple from the units digit; the carry/borrow stops at the first digit
  // that does not wrap, so 9999+1 and 0000-1 wrap naturally.
  function automatic bcd_vec_t bcd_step(bcd_vec_t v, logic down);
    bcd_vec_t r;
    logic     carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (down) begin
          if (v[i] == 4'd0) r[i] = 4'd9;
          else begin
            r[i]  = v[i] - 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (v[i] >= 4'd9) r[i] = 4'd0;
          else begin
            r[i]  = v[i] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_count_scheduler_if.sv
// Board-side signal bundle of the counter: load key, switches and the four
// seven-segment outputs.
//   KEY1      : active-low load pushbutton (asynchronous)
//   SW        : run / direction / blank controls and load value
//   HEX0..3   : [0:6] active-low segment outputs, HEX0 = units
// master = board/stimulus side, slave = counter side.
interface hex_count_scheduler_if;
  import seg7_pkg::*;

  logic        KEY1;
  logic [17:0] SW;
  seg_t        HEX0;
  seg_t        HEX1;
  seg_t        HEX2;
  seg_t        HEX3;

  modport master (output KEY1, SW, input HEX0, HEX1, HEX2, HEX3);
  modport slave  (input KEY1, SW, output HEX0, HEX1, HEX2, HEX3);

endinterface

// File: rtl/bcd7seg.sv
// Combinational BCD to seven-segment decoder, shared by all four digits.
//   code : 4-bit digit code (anything above 9 decodes to blank)
//   seg  : [0:6] active-low pattern, bit 0 = segment a
module bcd7seg
  import seg7_pkg::*;
(
  input  bcd_t code,
  output seg_t seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_count_scheduler.sv
// Four-digit BCD up/down counter displayed on HEX3..HEX0 through one
// shared decoder and a round-robin scan pipeline.
//   CLOCK_50 : clock, all state on rising edge
//   KEY0     : asynchronous active-low reset
//   io       : KEY1 load key, SW controls/load value, HEX0..HEX3 outputs
// SW[17] run, SW[16] down, SW[14] leading-zero blank, SW[15:0] load value.
module hex_count_scheduler
  import seg7_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                  CLOCK_50,
  input  logic                  KEY0,
  hex_count_scheduler_if.slave  io
);

  localparam int              PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

  logic          key_meta, key_sync, key_prev;
  logic [1:0]    sync_fill;
  logic          load_pulse;
  logic [PW-1:0] presc;
  logic          tick;
  bcd_vec_t      count, load_val;
  logic [NUM_DIGITS-1:0] blank;
  ptr_t          ptr, ptr_q;
  bcd_t          nib_q;
  logic          s1_valid;
  seg_t          seg;
  seg_t          hex [NUM_DIGITS];

  // sync_fill marks when key_sync holds a real sample of the pin; until then
  // key_prev stays low so a key held through reset release cannot fire.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      key_meta  <= 1'b1;
      key_sync  <= 1'b1;
      key_prev  <= 1'b0;
      sync_fill <= 2'b00;
    end else begin
      key_meta  <= io.KEY1;
      key_sync  <= key_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      key_prev  <= key_sync & sync_fill[1];
    end
  end

  assign load_pulse = key_prev & ~key_sync;
  assign tick       = io.SW[17] && (presc == PRESC_MAX);

  always_comb begin
    load_val = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      load_val[i] = clamp_digit(io.SW[4*i +: 4]);
    end
  end

  // Load has priority over a coincident tick.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      count <= '0;
      presc <= '0;
    end else if (load_pulse) begin
      count <= load_val;
      presc <= '0;
    end else if (io.SW[17]) begin
      if (tick) begin
        presc <= '0;
        count <= bcd_step(count, io.SW[16]);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank      = '0;
    for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
      upper_zero = upper_zero & (count[d] == 4'd0);
      blank[d]   = io.SW[14] & upper_zero;
    end
  end

  bcd7seg u_dec (
    .code (nib_q),
    .seg  (seg)
  );

  // Stage 1 latches the pointed digit, stage 2 writes the decoded pattern;
  // s1_valid keeps the first cycle after reset from writing HEX0 early.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      ptr      <= '0;
      ptr_q    <= '0;
      nib_q    <= '0;
      s1_valid <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) hex[i] <= SEG_BLANK;
    end else begin
      ptr      <= ptr + ptr_t'(1);
      ptr_q    <= ptr;
      nib_q    <= blank[ptr] ? BCD_BLANK : count[ptr];
      s1_valid <= 1'b1;
      if (s1_valid) hex[ptr_q] <= seg;
    end
  end

  assign io.HEX0 = hex[0];
  assign io.HEX1 = hex[1];
  assign io.HEX2 = hex[2];
  assign io.HEX3 = hex[3];

endmodule

// File: doc/hex_count_scheduler.md
# hex_count_scheduler

Four-digit BCD up/down counter whose digits share one BCD-to-7-segment decoder instance through a round-robin scan scheduler, driving DE2 displays HEX0–HEX3. Sits between the board switches/keys and the seven-segment outputs. Replaces one decoder per digit with one time-shared decoder plus per-digit output registers.

## Interface
- TICK_DIV, 50_000_000: CLOCK_50 cycles per count step; legal range 2 and up.
- CLOCK_50  in  1  board clock; all state on its rising edge.
- KEY0  in  1  asynchronous, active-low reset (pushbutton).
- KEY1  in  1  active-low load request (pushbutton, asynchronous to the clock).
- SW  in  18  SW[17] run; SW[16] direction (1 = down); SW[14] leading-zero blank; SW[15:0] load value when KEY1 fires: four BCD nibbles, SW[15:12] = thousands … SW[3:0] = units.
- HEX0..HEX3  out  7 each  [0:6], bit 0 = segment a … bit 6 = g, active-low; HEX0 = units.

Note: SW[15:14] are both a load nibble and other controls. This is intended. Bit 15 and bit 14 are sampled for the load only on a load pulse.

## Operation
- Count register: four BCD digits, each 0–9.
- Prescaler: counts 0..TICK_DIV-1 while SW[17]=1 and holds while SW[17]=0. Tick = prescaler at TICK_DIV-1; the prescaler then wraps to 0.
- On tick:
  - Up mode: BCD increment with carry; 9999 wraps to 0000.
  - Down mode: BCD decrement with borrow; 0000 wraps to 9999.
- Load:
  - KEY1 passes through a 2-FF synchronizer and a falling-edge detector, giving a 1-cycle load pulse.
  - Load copies SW[15:0] into the count. Any nibble > 9 is clamped to 9.
  - Load clears the prescaler to 0.
  - Load and tick in the same cycle: load wins and the tick is discarded.
- Scan scheduler:
  - 2-bit pointer cycles 0→1→2→3→0 every clock, unconditionally.
  - Stage 1: register the pointer and the selected digit nibble. If blanking applies, register 4'hF instead.
  - Stage 2: the shared decoder output is written into HEX[ptr_q]. The other three HEX registers hold.
- Blanking, when SW[14]=1:
  - A digit is blanked when every more-significant digit and the digit itself are 0.
  - The units digit is never blanked.
- Decoder mapping:
  - 0–9 map to 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
  - Any other code gives blank 1111111.

## Timing
- Reset (KEY0 low, asynchronous) clears:
  - count 0000, prescaler 0, pointer 0, stage-1 registers, synchronizer FFs (to 1 = released).
  - All HEX outputs to 1111111.
- After reset release, HEX0..HEX3 show "0" (or blank per SW[14]) within 5 cycles. HEXd is written on cycle d+2.
- Count change to display: the count is visible on HEXd no later than 5 cycles after the count register updates.
- Load latency: KEY1 falling edge → count updated 3 cycles later (2 synchronizer + 1 edge detect), then display per the rule above.
- Tick period: exactly TICK_DIV cycles while run is held; pausing and resuming keeps the prescaler phase.
- Direction change takes effect on the next tick; there is no lookahead.
- Reset asserted mid-scan or mid-load aborts immediately with no partial writes. A KEY1 held low through reset release does not generate a load.

## Structure
- Package seg7_pkg:
  - SEG_BLANK constant and the ten digit patterns.
  - bcd_t (4-bit) typedef and NUM_DIGITS = 4.
  - Scan pointer width.
- Sub-module bcd7seg: purely combinational 4-bit code → 7-bit [0:6] active-low pattern using the package constants. Instantiated exactly once.
- Remaining logic lives in the top: prescaler, synchronizer/edge detect, BCD counter, blank logic, scan pipeline, HEX registers.

## Test plan
- Reset: KEY0 low mid-operation → all HEX = 1111111 immediately and count = 0000. After release with SW[14]=0, all four HEX = 0000001 by cycle 5.
- Up count with wrap (TICK_DIV=4, SW[17]=1, SW[16]=0):
  - Load 9998 → after 2 ticks (8 cycles) count 0000; HEX3..HEX0 all 0000001 within 5 further cycles.
  - Carry checked at 0099 → 0100.
- Down count with borrow (SW[16]=1):
  - Load 0000, one tick → 9999, all HEX = 0000100.
  - Load 1000, one tick → 0999.
- Load edge cases:
  - SW[15:0]=16'hA3F5 → count 9395.
  - KEY1 low coinciding with the tick cycle → count equals the load value, and the next tick occurs TICK_DIV cycles after the load.
- Blanking: SW[14]=1, count 0040 → HEX3 = HEX2 = 1111111, HEX1 = 1001100, HEX0 = 0000001; count 0000 → only HEX0 shows 0000001.
- Pause: SW[17] dropped for 10 cycles at prescaler=2 → no count change. Re-asserted → tick after exactly 2 more cycles (TICK_DIV=4).
